// File: rtl/adat_pkg.sv
// ADAT framing constants and shared types.
// Used by the TX framer and the frame packer.
package adat_pkg;

  localparam int ADAT_FRAME_BITS = 256;
  localparam int ADAT_SYNC_ZEROS = 10;
  localparam int ADAT_MAX_CH     = 8;
  localparam int ADAT_SLOT_W     = 24;
  localparam int ADAT_NIB_PER_CH = ADAT_SLOT_W / 4;
  localparam int ADAT_CH_BITS    = ADAT_NIB_PER_CH * 5;
  localparam int ADAT_AUDIO_TOP  = ADAT_FRAME_BITS - 17;

  typedef logic [ADAT_FRAME_BITS-1:0] adat_frame_t;
  typedef logic [ADAT_SLOT_W-1:0] adat_slot_t;

  typedef struct packed {
    logic timecode;
    logic midi;
    logic smux;
  } adat_user_t;

  // one audio nibble with its leading framing 1
  function automatic logic [4:0] adat_nib(
    input logic [3:0] n
  );
    return {1'b1, n};
  endfunction

endpackage

// File: rtl/adat_tx_framer_if.sv
// Frame handshake bus between mixer and ADAT framer.
// The source drives samples/user bits; the framer drives ready.
interface adat_tx_framer_if #(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 24
);

  logic                       frame_valid;
  logic                       frame_ready;
  logic signed [SAMPLE_W-1:0] audio_in [NUM_CH];
  logic [2:0]                 user_in;

  modport master (
    output frame_valid,
    output audio_in,
    output user_in,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  audio_in,
    input  user_in,
    output frame_ready
  );

endinterface

// File: rtl/adat_frame_packer.sv
// Combinational ADAT frame builder: sync, user nibble,
// then eight 24-bit slots as 1-prefixed nibbles, MSB first.
module adat_frame_packer
  import adat_pkg::*;
(
  input  adat_slot_t  slots [ADAT_MAX_CH],
  input  adat_user_t  user,
  output adat_frame_t frame
);

  // lay out every field at its fixed bit position
  always_comb begin
    frame = '0;
    frame[ADAT_FRAME_BITS-1 -: ADAT_SYNC_ZEROS+1] =
      {1'b1, {ADAT_SYNC_ZEROS{1'b0}}};
    frame[ADAT_AUDIO_TOP+5 -: 5] =
      {1'b1, user.timecode, user.midi, user.smux, 1'b0};
    for (int c = 0; c < ADAT_MAX_CH; c++) begin
      for (int n = 0; n < ADAT_NIB_PER_CH; n++) begin
        frame[ADAT_AUDIO_TOP - c*ADAT_CH_BITS - n*5 -: 5] =
          adat_nib(slots[c][ADAT_SLOT_W-1 - 4*n -: 4]);
      end
    end
  end

endmodule

// File: rtl/adat_tx_framer.sv
// ADAT lightpipe transmitter with own frame timing,
// a one-frame holding register and underrun detection.
module adat_tx_framer
  import adat_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_W   = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  adat_tx_framer_if.slave  fin,
  input  logic             underrun_clr,
  output logic             underrun,
  output logic             frame_start,
  output logic             bitstream_out
);

  localparam int PH_W = (OVERSAMPLE > 1) ?
    $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = $clog2(ADAT_FRAME_BITS);
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(OVERSAMPLE - 1);

  logic [PH_W-1:0]  phase;
  logic [BIT_W-1:0] bit_cnt;
  adat_frame_t      shift_reg;
  adat_frame_t      packed_frame;
  logic             hold_full;
  adat_slot_t       in_slot   [ADAT_MAX_CH];
  adat_slot_t       hold_slot [ADAT_MAX_CH];
  adat_slot_t       pack_slot [ADAT_MAX_CH];
  adat_user_t       hold_user;
  adat_user_t       pack_user;
  logic             boundary;
  logic             accept;

  assign boundary = enable && (phase == '0) &&
                    (bit_cnt == '0);
  assign accept   = fin.frame_valid && fin.frame_ready;

  // MSB-align active channels; unused slots send zero
  for (genvar c = 0; c < ADAT_MAX_CH; c++) begin : g_slot
    if (c < NUM_CH) begin : g_on
      assign in_slot[c] =
        ADAT_SLOT_W'(fin.audio_in[c]) <<
        (ADAT_SLOT_W - SAMPLE_W);
    end else begin : g_off
      assign in_slot[c] = '0;
    end
  end

  // an empty holding register packs as a silence frame
  always_comb begin
    pack_user = hold_full ? hold_user : '0;
    for (int c = 0; c < ADAT_MAX_CH; c++) begin
      pack_slot[c] = hold_full ? hold_slot[c] : '0;
    end
  end

  adat_frame_packer u_packer (
    .slots (pack_slot),
    .user  (pack_user),
    .frame (packed_frame)
  );

  // holding register and registered ready; no bypass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full       <= 1'b0;
      fin.frame_ready <= 1'b1;
      hold_user       <= '0;
      hold_slot       <= '{default: '0};
    end else begin
      if (boundary && hold_full) begin
        hold_full       <= 1'b0;
        fin.frame_ready <= 1'b1;
      end
      if (accept) begin
        hold_full       <= 1'b1;
        fin.frame_ready <= 1'b0;
        hold_slot       <= in_slot;
        hold_user       <= adat_user_t'(fin.user_in);
      end
    end
  end

  // bit timing: phase within a bit, bit within a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else if (!enable) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else if (phase == PH_LAST) begin
      phase   <= '0;
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // NRZI serialiser; frame bit 255 is emitted at load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg     <= '0;
      bitstream_out <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        shift_reg     <= packed_frame << 1;
        bitstream_out <= ~bitstream_out;
      end else if (enable && (phase == '0)) begin
        bitstream_out <= bitstream_out ^
                         shift_reg[ADAT_FRAME_BITS-1];
        shift_reg     <= shift_reg << 1;
      end
    end
  end

  // sticky underrun; a new set beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (boundary && !hold_full) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adat_tx_framer.sv
// Self-checking bench: frame-level model, NRZI decoder,
// directed scenarios with literal expectations.
module tb_adat_tx_framer;
  import adat_pkg::*;

  localparam int OS  = 8;
  localparam int P   = 256 * OS;
  localparam int OSB = 4;

  logic clk = 0;
  logic reset_n = 1;
  logic en_a = 0, clr_a = 0, en_b = 0, clr_b = 0;
  logic und_a, fs_a, out_a;
  logic und_b, fs_b, out_b;
  int nchk = 0, nerr = 0;
  bit armed = 0;

  adat_tx_framer_if #(.NUM_CH(8), .SAMPLE_W(24)) ifa ();
  adat_tx_framer_if #(.NUM_CH(2), .SAMPLE_W(16)) ifb ();

  always #5 clk = ~clk;

  adat_tx_framer #(
    .OVERSAMPLE(OS), .NUM_CH(8), .SAMPLE_W(24)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a),
    .fin(ifa.slave), .underrun_clr(clr_a),
    .underrun(und_a), .frame_start(fs_a),
    .bitstream_out(out_a)
  );

  adat_tx_framer #(
    .OVERSAMPLE(OSB), .NUM_CH(2), .SAMPLE_W(16)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b),
    .fin(ifb.slave), .underrun_clr(clr_b),
    .underrun(und_b), .frame_start(fs_b),
    .bitstream_out(out_b)
  );

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // expected frame, built bit by bit from the format rules
  function automatic adat_frame_t mk(logic [2:0] u,
                                     logic [191:0] s);
    adat_frame_t f = '0;
    int p = 255;
    logic [4:0] un = {1'b1, u, 1'b0};
    f[p] = 1'b1; p--;
    repeat (10) begin f[p] = 1'b0; p--; end
    for (int i = 4; i >= 0; i--) begin f[p] = un[i]; p--; end
    for (int ch = 0; ch < 8; ch++)
      for (int n = 0; n < 6; n++) begin
        f[p] = 1'b1; p--;
        for (int b = 3; b >= 0; b--) begin
          f[p] = s[ch*24 + 20 - 4*n + b]; p--;
        end
      end
    return f;
  endfunction

  function automatic logic [191:0] slots_a();
    logic [191:0] s;
    for (int c = 0; c < 8; c++) s[c*24 +: 24] = ifa.audio_in[c];
    return s;
  endfunction

  function automatic logic [23:0] slot_of(adat_frame_t f, int c);
    logic [23:0] s;
    for (int n = 0; n < 6; n++)
      s[23-4*n -: 4] = f[238 - 30*c - 5*n -: 4];
    return s;
  endfunction

  function automatic bit marks_ok(adat_frame_t f);
    bit ok = 1;
    for (int k = 0; k < 48; k++) if (!f[239 - 5*k]) ok = 0;
    return ok;
  endfunction

  // frame-level model: which frame leaves at each boundary
  adat_frame_t expq[$];
  logic m_ready = 1, m_und = 0, m_fs = 0, m_full = 0;
  logic [2:0] m_user = 0;
  logic [191:0] m_slots = 0;
  int ecnt = 0;
  bit mb, macc, mset;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_ready = 1; m_und = 0; m_fs = 0; m_full = 0;
      ecnt = 0; expq.delete();
    end else begin
      mb = en_a && (ecnt % P == 0);
      macc = ifa.frame_valid && m_ready;
      mset = 0;
      if (mb) begin
        if (m_full) begin
          expq.push_back(mk(m_user, m_slots));
          m_full = 0; m_ready = 1;
        end else begin
          expq.push_back(mk(3'b0, 192'b0));
          mset = 1;
        end
      end
      if (macc) begin
        m_full = 1; m_ready = 0;
        m_user = ifa.user_in; m_slots = slots_a();
      end
      if (mset) m_und = 1;
      else if (clr_a) m_und = 0;
      m_fs = mb;
      ecnt = en_a ? ecnt + 1 : 0;
    end
  end

  // compare process: flags every cycle, decoded frames at end
  adat_frame_t got[$];
  int fs_cyc[$];
  int cyc = 0;
  bit cap = 0;
  adat_frame_t fr;
  int bi, cc;
  logic lvl = 0, ls;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      cap = 0;
    end else if (armed) begin
      chk("frame_ready", ifa.frame_ready, m_ready);
      chk("underrun", und_a, m_und);
      chk("frame_start", fs_a, m_fs);
      if (fs_a) fs_cyc.push_back(cyc);
      if (cap && !en_a) begin
        cap = 0;
        if (expq.size() > 0) void'(expq.pop_front());
      end else if (cap) begin
        cc++;
        if (cc == OS) begin
          cc = 0; fr[bi] = out_a ^ ls; ls = out_a;
          if (bi == 0) begin
            cap = 0;
            if (expq.size() == 0) begin
              nchk++; nerr++;
              $display("FAIL frame_unexpected got=%h", fr);
            end else chk("frame", fr, expq.pop_front());
            got.push_back(fr);
          end else bi--;
        end
      end else if (fs_a) begin
        cap = 1; fr = '0; fr[255] = out_a ^ lvl;
        bi = 254; cc = 0; ls = out_a;
      end
    end
    lvl = out_a;
  end

  // decoder for the narrow instance (first frame only)
  bit capb = 0, doneb = 0, b_done = 0;
  adat_frame_t frb;
  int bib, ccb;
  logic lvlb = 0, lsb;

  initial forever begin
    @(negedge clk);
    if (!reset_n) capb = 0;
    else if (capb) begin
      ccb++;
      if (ccb == OSB) begin
        ccb = 0; frb[bib] = out_b ^ lsb; lsb = out_b;
        if (bib == 0) begin capb = 0; doneb = 1; end
        else bib--;
      end
    end else if (fs_b && !doneb && armed) begin
      capb = 1; frb = '0; frb[255] = out_b ^ lvlb;
      bib = 254; ccb = 0; lsb = out_b;
    end
    lvlb = out_b;
  end

  task automatic wait_dec(int n, int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin tick(); k++; end
    chk("wait_frames", got.size() >= n, 1);
  endtask

  task automatic wait_fs();
    int k = 0;
    while (!fs_a && k < P + 16) begin tick(); k++; end
    chk("wait_fs", fs_a, 1);
  endtask

  // narrow instance: 2 channels, 16-bit samples
  initial begin
    int k;
    ifb.frame_valid = 0; ifb.user_in = 0;
    ifb.audio_in[0] = 0; ifb.audio_in[1] = 0;
    wait (armed);
    tick();
    ifb.audio_in[0] = 16'h1234;
    ifb.audio_in[1] = 16'h8001;
    ifb.frame_valid = 1;
    tick();
    ifb.frame_valid = 0;
    en_b = 1;
    k = 0;
    while (!doneb && k < 3 * 256 * OSB) begin tick(); k++; end
    chk("b_decoded", doneb, 1);
    chk("b_header", frb[255:240], 16'h8010);
    chk("b_markers", marks_ok(frb), 1);
    chk("b_slot0", slot_of(frb, 0), 24'h123400);
    chk("b_slot1", slot_of(frb, 1), 24'h800100);
    for (int c = 2; c < 8; c++) chk("b_slot_zero", slot_of(frb, c), 0);
    chk("b_underrun", und_b, 0);
    en_b = 0;
    b_done = 1;
  end

  initial begin
    int n, acc, k;
    logic r;
    ifa.frame_valid = 0; ifa.user_in = 0;
    for (int c = 0; c < 8; c++) ifa.audio_in[c] = 0;
    #1 reset_n = 0;
    #1;
    chk("rst_out", out_a, 0);
    chk("rst_ready", ifa.frame_ready, 1);
    chk("rst_underrun", und_a, 0);
    chk("rst_fs", fs_a, 0);
    tick(); tick();
    reset_n = 1; armed = 1;
    tick();

    // 1: idle stream of silence frames
    en_a = 1;
    tick();
    chk("t1_underrun", und_a, 1);
    chk("t1_first_bit", out_a, 1);
    wait_dec(2, 3 * P);
    chk("t1_header", got[0][255:240], 16'h8010);
    chk("t1_audio", got[0][239:0], {48{5'b10000}});
    chk("t1_period", fs_cyc[1] - fs_cyc[0], P);
    en_a = 0; tick();
    clr_a = 1; tick(); clr_a = 0;
    chk("t1_clr", und_a, 0);

    // 2: one frame loaded while idle
    ifa.audio_in[0] = 24'hABCDEF;
    ifa.user_in = 3'b101;
    ifa.frame_valid = 1;
    tick();
    ifa.frame_valid = 0;
    chk("t2_ready_low", ifa.frame_ready, 0);
    n = got.size();
    en_a = 1;
    wait_dec(n + 1, 2 * P);
    chk("t2_header", got[n][255:240], 16'h801A);
    chk("t2_ch0", got[n][239:210],
        30'b11010_11011_11100_11101_11110_11111);
    chk("t2_rest", got[n][209:0], {42{5'b10000}});
    chk("t2_no_underrun", und_a, 0);
    en_a = 0;
    ifa.audio_in[0] = 0; ifa.user_in = 0;
    tick();

    // 3: back-to-back frames, ch7 counting up
    n = got.size(); acc = 0; k = 0;
    ifa.audio_in[7] = 1;
    ifa.frame_valid = 1;
    while (acc < 16 && k < 20 * P) begin
      r = ifa.frame_ready;
      tick(); k++;
      if (r) begin acc++; ifa.audio_in[7] = 24'(acc + 1); end
      if (acc >= 1) en_a = 1;
    end
    ifa.frame_valid = 0;
    chk("t3_accepts", acc, 16);
    wait_dec(n + 16, 18 * P);
    chk("t3_no_underrun", und_a, 0);
    chk("t3_last_ch7", got[n+15][29:0],
        30'b10000_10000_10000_10000_10001_10000);
    en_a = 0;
    ifa.audio_in[7] = 0;
    tick();

    // 5: valid only in the boundary cycle; clear vs set
    clr_a = 1; tick(); clr_a = 0;
    n = got.size();
    ifa.audio_in[3] = 24'h5A5A5A;
    ifa.user_in = 3'b010;
    ifa.frame_valid = 1;
    en_a = 1;
    tick();
    ifa.frame_valid = 0;
    chk("t5_underrun", und_a, 1);
    chk("t5_ready_low", ifa.frame_ready, 0);
    clr_a = 1; tick(); clr_a = 0;
    chk("t5_clr", und_a, 0);
    wait_fs();
    repeat (P - 1) tick();
    clr_a = 1; tick(); clr_a = 0;
    chk("t5_set_wins", und_a, 1);
    wait_dec(n + 2, 2 * P);
    chk("t5_silence_hdr", got[n][255:240], 16'h8010);
    chk("t5_late_hdr", got[n+1][255:240], 16'h8014);
    chk("t5_late_ch3", got[n+1][149:120],
        30'b10101_11010_10101_11010_10101_11010);
    ifa.audio_in[3] = 0; ifa.user_in = 0;

    // 6: reset mid-frame, then restart from line level 0
    wait_fs();
    repeat (100 * OS) tick();
    #1 reset_n = 0;
    #1;
    chk("t6_out", out_a, 0);
    chk("t6_ready", ifa.frame_ready, 1);
    chk("t6_underrun", und_a, 0);
    chk("t6_fs", fs_a, 0);
    tick(); tick();
    chk("t6_out_held", out_a, 0);
    reset_n = 1;
    n = got.size();
    tick();
    chk("t6_fs_after", fs_a, 1);
    chk("t6_sync_edge", out_a, 1);
    chk("t6_underrun_after", und_a, 1);
    wait_dec(n + 1, 2 * P);
    chk("t6_header", got[n][255:240], 16'h8010);

    k = 0;
    while (!b_done && k < 1000) begin tick(); k++; end
    chk("b_finished", b_done, 1);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
